// File: rtl/csa_seq_pkg.sv
// Shared types and helpers for the nibble-serial carry-select adder.
// Provides the FSM state encoding, the slice width and an index-width helper.
package csa_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // ceil(log2(n)), never less than 1 so a single-nibble
  // build still gets a legal index register.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/csa_nibble_seq_adder_csa_4bit.sv
// CSA_4bit: 4-bit carry-select adder slice (two 2-bit halves).
// Ports: a, b, cin in; sum, cout out. Purely combinational.
module CSA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;
  logic [2:0] hi;

  // Upper half is precomputed for both carries and
  // selected once the lower half's carry resolves.
  assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
  assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
  assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
  assign hi  = lo[2] ? hi1 : hi0;

  assign sum  = {hi[1:0], lo[1:0]};
  assign cout = hi[2];

endmodule

// File: rtl/csa_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one CSA_4bit slice, one nibble per clock, LSB first.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b/in_cin; out_valid/out_ready/
// out_sum/out_cout; busy. CSA_SEQ_OVF_FLAG_EN adds out_ovf (signed overflow).
module csa_nibble_seq_adder
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef CSA_SEQ_OVF_FLAG_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = clog2(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("csa_nibble_seq_adder: WIDTH must be a multiple of 4, >= 4");
  end

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic [NIB_W-1:0] sl_a;
  logic [NIB_W-1:0] sl_b;
  logic [NIB_W-1:0] sl_sum;
  logic             sl_cout;

  assign sl_a = a_q[NIB_W*idx_q +: NIB_W];
  assign sl_b = b_q[NIB_W*idx_q +: NIB_W];

  CSA_4bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = BUSY;
      BUSY: if (idx_q == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            sum_q   <= '0;
            carry_q <= in_cin;
            idx_q   <= '0;
          end
        end
        BUSY: begin
          sum_q[NIB_W*idx_q +: NIB_W] <= sl_sum;
          carry_q <= sl_cout;
          idx_q   <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;

`ifdef CSA_SEQ_OVF_FLAG_EN
  // Same-sign operands whose result sign differs.
  assign out_ovf = (state_q == DONE)
                && (a_q[WIDTH-1] == b_q[WIDTH-1])
                && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
`endif

endmodule

// File: tb/tb_csa_nibble_seq_adder.sv
// Self-checking bench for csa_nibble_seq_adder (WIDTH=16 and WIDTH=4).
// Random and directed operands checked against plain-arithmetic model.
module tb_csa_nibble_seq_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk;
  logic rst_n;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  logic       v4;
  logic       r4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       c4;
  logic       ov4;
  logic       ordy4;
  logic [3:0] s4;
  logic       co4;
  logic       busy4;

`ifdef CSA_SEQ_OVF_FLAG_EN
  logic out_ovf;
  logic ovf4;
`endif

  int n_checks;
  int n_errors;

  csa_nibble_seq_adder #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef CSA_SEQ_OVF_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  csa_nibble_seq_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .in_ready  (r4),
    .in_a      (a4),
    .in_b      (b4),
    .in_cin    (c4),
    .out_valid (ov4),
    .out_ready (ordy4),
    .out_sum   (s4),
    .out_cout  (co4),
`ifdef CSA_SEQ_OVF_FLAG_EN
    .out_ovf   (ovf4),
`endif
    .busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic c,
                        input int hold);
    logic [W:0]   ref_v;
    logic [W-1:0] s_seen;
    logic         c_seen;
    int k;
    ref_v = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = c;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_cin = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    k = 0;
    while (!out_valid && k < 20) begin
      check("ready_low_busy", 32'(in_ready), 32'd0);
      out_ready = 1'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("latency", 32'(k), 32'(NIB));
    check("sum", 32'(out_sum), 32'(ref_v[W-1:0]));
    check("cout", 32'(out_cout), 32'(ref_v[W]));
`ifdef CSA_SEQ_OVF_FLAG_EN
    check("ovf", 32'(out_ovf),
          32'((a[W-1] == b[W-1]) && (ref_v[W-1] != a[W-1])));
`endif
    s_seen = out_sum;
    c_seen = out_cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = 16'h1111;
      in_b = W'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(out_sum), 32'(s_seen));
      check("hold_cout", 32'(out_cout), 32'(c_seen));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    // in_valid high together with out_ready must not start a new op.
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [4:0] ref4;
    int k4;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    out_ready = 1'b0;
    v4 = 1'b0;
    a4 = '0;
    b4 = '0;
    c4 = 1'b0;
    ordy4 = 1'b0;
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_cout", 32'(out_cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1);
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 6);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'hFFFF, 1'b0, 0);

    // Reset in the middle of an operation.
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 16'hABCD;
    in_b = 16'h1111;
    in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(out_sum), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    run_op(16'h0F0F, 16'hF0F0, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    // Exhaustive single-nibble build.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          ref4 = 5'(a) + 5'(b) + 5'(c);
          @(negedge clk);
          v4 = 1'b1;
          a4 = 4'(a);
          b4 = 4'(b);
          c4 = 1'(c);
          @(negedge clk);
          v4 = 1'b0;
          a4 = 4'($urandom);
          b4 = 4'($urandom);
          k4 = 0;
          while (!ov4 && k4 < 10) begin
            @(negedge clk);
            k4++;
          end
          check("w4_latency", 32'(k4), 32'd1);
          check("w4_sum", 32'(s4), 32'(ref4[3:0]));
          check("w4_cout", 32'(co4), 32'(ref4[4]));
          ordy4 = 1'b1;
          @(negedge clk);
          ordy4 = 1'b0;
          check("w4_idle", 32'(r4), 32'd1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csa_nibble_seq_adder.md
Name: csa_nibble_seq_adder

Overview:
Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-select adder slice, one nibble per clock, LSB nibble first.
- Holds inter-nibble carry in a register.
- Valid/ready handshake on input and output.
- Sits between an operand source (register file or test sequencer) and a result consumer where area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NIB, WIDTH/4, derived nibble count; not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands (high only in IDLE)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in to nibble 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  A+B+cin, low WIDTH bits
out_cout  output  1  carry out of the top nibble
busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately at any time, including mid-operation):
  - state=IDLE; operand, result, carry and index registers cleared.
  - in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0.
  - Any in-flight operation is discarded with no output.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T0: latch in_a, in_b, carry_q<=in_cin, idx<=0, go to BUSY.
  - BUSY: in_ready=0.
    - Each edge: slice inputs are a_q[4*idx+:4], b_q[4*idx+:4], carry_q.
    - Slice sum is written to sum_q[4*idx+:4]; carry_q<=slice carry out; idx<=idx+1.
    - On the edge that processes idx==NIB-1: go to DONE, out_valid<=1.
  - DONE: out_valid=1; out_sum=sum_q and out_cout=carry_q held stable. On out_ready high at an edge: go to IDLE, out_valid<=0.
- Latency: out_valid rises exactly NIB edges after the accept edge (WIDTH=16: accept at T0, out_valid visible after T4).
- Throughput: at most one operation per NIB+2 cycles. No accept in DONE, even with out_ready=1 in the same cycle.
- in_valid is ignored outside IDLE. Operand inputs may change freely after the accept edge.
- out_ready is ignored outside DONE.
- Arithmetic:
  - Sum wraps modulo 2^WIDTH; out_cout is bit WIDTH of A+B+cin.
  - idx width is clog2(NIB), minimum 1 bit.
  - WIDTH=4 degenerates to one BUSY cycle.
- sum_q is cleared on accept, so out_sum never shows stale nibbles from the previous operation.

Optional Feature:
CSA_SEQ_OVF_FLAG_EN
- Defined: adds output out_ovf (1 bit), registered with out_sum.
  - out_ovf = two's-complement signed overflow = (a_q[WIDTH-1]==b_q[WIDTH-1]) && (sum_q[WIDTH-1]!=a_q[WIDTH-1]).
  - Valid while out_valid=1; 0 at reset and in IDLE.
- Undefined: port and logic absent; remaining behaviour identical.

Decomposition:
- Shared package csa_seq_pkg:
  - state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - NIB_W=4 constant.
  - clog2 helper function for idx width.
- One sub-module: the team's existing 4-bit carry-select adder slice CSA_4bit, instantiated once as the datapath.
- FSM, carry/index registers and result register live in csa_nibble_seq_adder.

Test Plan:
1. WIDTH=16, A=0x1234, B=0x4321, cin=0, out_ready=1 -> out_sum=0x5555, out_cout=0, out_valid high exactly 4 edges after accept, in_ready low until back in IDLE.
2. A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, out_cout=1 (carry propagates through all 4 nibbles). Then A=0xFFFF, B=0x0000, cin=1 -> 0x0000, cout=1.
3. Backpressure: out_ready held 0 for 6 cycles after out_valid, in_valid pulsed with A=0x1111 during that time -> out_sum/out_cout stable, in_ready=0, new operands ignored; out_ready=1 -> IDLE next edge.
4. Reset mid-BUSY: assert rst_n=0 after 2 nibble edges of 0xABCD+0x1111 -> out_valid=0, out_sum=0 immediately, no result emitted. Release, run 0x0F0F+0xF0F0 cin=1 -> out_sum=0x0000, cout=1.
5. Exhaustive WIDTH=4 build: all 16x16x2 (A,B,cin) combinations -> out_sum/out_cout match the reference model; 1-cycle BUSY latency each time.
6. With CSA_SEQ_OVF_FLAG_EN: 0x7FFF+0x0001 -> out_ovf=1, cout=0; 0x8000+0xFFFF -> out_ovf=1, cout=1; 0x1234+0x4321 -> out_ovf=0.
